// File: rtl/hazard_unit.sv
// Stall/flush controller for the five-stage pipeline: load-use interlock, multi-cycle
// divide hold and taken-branch flush, plus saturating stall/flush performance counters.
module hazard_unit #(
    parameter int DIV_CYCLES = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             if_id_rs1_used,
    input  logic             if_id_rs2_used,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_ins_valid,
    input  logic             id_ex_mem_read,
    input  logic             id_ex_is_div,
    input  logic             ex_branch_taken,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_bubble,
    output logic             ex_hold,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {RUN, DIV_BUSY} state_t;

    // Entry cycle is itself a hold cycle, so the busy phase counts down from DIV_CYCLES-2.
    localparam logic [7:0] DIV_INIT = 8'(DIV_CYCLES - 2);

    state_t           state_q, state_d;
    logic [7:0]       div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             load_use, div_entry;

    assign load_use = id_ex_ins_valid & id_ex_mem_read & (id_ex_rd != 5'd0) &
                      ((if_id_rs1_used & (if_id_rs1 == id_ex_rd)) |
                       (if_id_rs2_used & (if_id_rs2 == id_ex_rd)));
    assign div_entry = id_ex_ins_valid & id_ex_is_div;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            div_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        case (state_q)
            RUN: begin
                if (!ex_branch_taken && div_entry) begin
                    state_d   = DIV_BUSY;
                    div_cnt_d = DIV_INIT;
                end
            end
            DIV_BUSY: begin
                if (div_cnt_q != 8'd0) div_cnt_d = div_cnt_q - 8'd1;
                else                   state_d   = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_hold      = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (div_entry) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        ex_hold     = 1'b1;
                    end else if (load_use) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end
                end
                DIV_BUSY: begin
                    // Final busy cycle releases everything so the quotient moves on.
                    pc_stall    = (div_cnt_q != 8'd0);
                    if_id_stall = (div_cnt_q != 8'd0);
                    ex_hold     = (div_cnt_q != 8'd0);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (pc_stall && (stall_q != '1))    stall_q <= stall_q + 1'b1;
            if (if_id_flush && (flush_q != '1)) flush_q <= flush_q + 1'b1;
        end
    end

    assign busy         = (state_q == DIV_BUSY);
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two instances (DIV_CYCLES=8/CNT_W=32 and DIV_CYCLES=2/CNT_W=4)
// driven by directed and random stimulus and compared against a cycle-indexed model.
module tb_hazard_unit;
    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, valid, mrd, isdiv, br;

    logic [5:0]  ctl [2];
    logic        bsy [2];
    logic [31:0] sc_o0, fc_o0;
    logic [3:0]  sc_o1, fc_o1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_unit #(.DIV_CYCLES(8), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .if_id_rs1(rs1), .if_id_rs2(rs2),
        .if_id_rs1_used(u1), .if_id_rs2_used(u2), .id_ex_rd(rd),
        .id_ex_ins_valid(valid), .id_ex_mem_read(mrd), .id_ex_is_div(isdiv),
        .ex_branch_taken(br),
        .pc_stall(ctl[0][5]), .if_id_stall(ctl[0][4]), .id_ex_bubble(ctl[0][3]),
        .ex_hold(ctl[0][2]), .if_id_flush(ctl[0][1]), .id_ex_flush(ctl[0][0]),
        .busy(bsy[0]), .stall_cycles(sc_o0), .flush_count(fc_o0));

    hazard_unit #(.DIV_CYCLES(2), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .if_id_rs1(rs1), .if_id_rs2(rs2),
        .if_id_rs1_used(u1), .if_id_rs2_used(u2), .id_ex_rd(rd),
        .id_ex_ins_valid(valid), .id_ex_mem_read(mrd), .id_ex_is_div(isdiv),
        .ex_branch_taken(br),
        .pc_stall(ctl[1][5]), .if_id_stall(ctl[1][4]), .id_ex_bubble(ctl[1][3]),
        .ex_hold(ctl[1][2]), .if_id_flush(ctl[1][1]), .id_ex_flush(ctl[1][0]),
        .busy(bsy[1]), .stall_cycles(sc_o1), .flush_count(fc_o1));

    // Model: a divide entered at cycle ds occupies EX for cycles ds..ds+DC-1,
    // holds the front end on ds..ds+DC-2, and the FSM is busy on ds+1..ds+DC-1.
    int     dcv [2] = '{8, 2};
    longint mx  [2] = '{64'hFFFF_FFFF, 64'd15};
    longint ds  [2] = '{-1, -1};
    longint sc  [2] = '{0, 0};
    longint fc  [2] = '{0, 0};
    longint cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cyc%0d: got %0h want %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        logic [5:0] e [2];
        logic       ent [2];
        logic       bz, lu;
        logic [31:0] sco, fco;
        @(negedge clk);
        lu = valid && mrd && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        for (int k = 0; k < 2; k++) begin
            e[k] = 6'b0; ent[k] = 1'b0; bz = 1'b0;
            if (rst) begin
                ds[k] = -1; sc[k] = 0; fc[k] = 0;
            end else begin
                bz = ds[k] >= 0 && cyc > ds[k] && cyc <= ds[k] + dcv[k] - 1;
                if (bz) begin
                    if (cyc - ds[k] < dcv[k] - 1) e[k] = 6'b110100;
                end else if (br)              e[k] = 6'b000011;
                else if (valid && isdiv) begin e[k] = 6'b110100; ent[k] = 1'b1; end
                else if (lu)                  e[k] = 6'b111000;
            end
            sco = (k == 0) ? sc_o0 : 32'(sc_o1);
            fco = (k == 0) ? fc_o0 : 32'(fc_o1);
            chk($sformatf("ctl%0d", k), 32'(ctl[k]), 32'(e[k]));
            chk($sformatf("busy%0d", k), 32'(bsy[k]), 32'(bz));
            chk($sformatf("stalls%0d", k), sco, 32'(sc[k]));
            chk($sformatf("flushes%0d", k), fco, 32'(fc[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                if (ent[k]) ds[k] = cyc;
                if (e[k][5] && sc[k] < mx[k]) sc[k]++;
                if (e[k][1] && fc[k] < mx[k]) fc[k]++;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle();
        rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0;
        valid = 0; mrd = 0; isdiv = 0; br = 0;
    endtask

    task automatic load(input logic [4:0] d, input logic [4:0] s1, input logic s1u,
                        input logic [4:0] s2, input logic s2u);
        idle();
        valid = 1; mrd = 1; rd = d; rs1 = s1; u1 = s1u; rs2 = s2; u2 = s2u;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
        step();
        // load-use on rs2, then the bubble clears it
        load(5, 0, 0, 5, 1); step();
        idle(); step();
        // x0 destination and unused source never stall
        load(0, 0, 1, 0, 1); step();
        load(7, 7, 0, 0, 1); step();
        // divide held in EX across the busy window (back-to-back for the short instance)
        idle(); valid = 1; isdiv = 1;
        repeat (8) step();
        idle(); step();
        // branch with a matching load: flush wins
        load(3, 3, 1, 0, 0); br = 1; step();
        idle(); step();
        // reset in the middle of a divide, then a full divide afterwards
        valid = 1; isdiv = 1; step();
        idle(); repeat (2) step();
        rst = 1'b1; step();
        rst = 1'b0; step();
        valid = 1; isdiv = 1; step();
        idle(); repeat (8) step();
        // sustained load-use stalls drive the 4-bit counter into saturation
        load(9, 9, 1, 0, 0);
        repeat (20) step();
        idle(); step();
        // random traffic
        for (int i = 0; i < 400; i++) begin
            rs1   = 5'($urandom_range(0, 3));
            rs2   = 5'($urandom_range(0, 3));
            rd    = 5'($urandom_range(0, 3));
            u1    = 1'($urandom);
            u2    = 1'($urandom);
            valid = ($urandom_range(0, 9) < 8);
            mrd   = 1'($urandom);
            isdiv = ($urandom_range(0, 9) == 0);
            br    = ($urandom_range(0, 9) < 2);
            rst   = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; idle(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
